// File: rtl/icb_arbt_mux_pkg.sv
// -----------------------------------------------------------------------------
// icb_arbt_mux_pkg
// Shared types and helpers for the ICB N-to-1 arbiter.
//   arb_state_e    : arbitration FSM encoding. ST_LOCK is present only when
//                    ICB_ARBT_LOCK_EN is defined.
//   onehot_to_idx  : index of the set bit of a one-hot vector (up to 32 bits).
// -----------------------------------------------------------------------------
package icb_arbt_mux_pkg;

`ifdef ICB_ARBT_LOCK_EN
   typedef enum logic [1:0] {
      ST_ARB  = 2'd0,
      ST_HOLD = 2'd1,
      ST_LOCK = 2'd2
   } arb_state_e;
`else
   typedef enum logic [1:0] {
      ST_ARB  = 2'd0,
      ST_HOLD = 2'd1
   } arb_state_e;
`endif

   function automatic int onehot_to_idx(input logic [31:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/icb_arbt_mux_fifo.sv
// -----------------------------------------------------------------------------
// icb_arbt_mux_fifo
// Outstanding-ID FIFO for the arbiter. DP=1 collapses to a single pipe stage.
// The head is not zeroed when empty; consumers must qualify it with empty.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   push, din    write one entry (caller guarantees not full)
//   pop, dout    consume the head entry (caller guarantees not empty)
//   empty, full  occupancy flags; full reflects the registered count, so a
//                pop does not free a slot until the following cycle
// Parameters: DP depth, DW entry width, CUT_READY 1 = full from its own flop.
// -----------------------------------------------------------------------------
module icb_arbt_mux_fifo #(
   parameter int DP        = 8,
   parameter int DW        = 4,
   parameter int CUT_READY = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          empty,
   output logic          full
);

   generate
      if (DP == 1) begin : g_stage
         logic          vld;
         logic [DW-1:0] dat;

         // NOTE: sequential state is always written with <= so every flop
         // samples the pre-edge values regardless of statement order.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)      vld <= 1'b0;
            else if (push) vld <= 1'b1;
            else if (pop)  vld <= 1'b0;
         end

         always_ff @(posedge clk) begin
            if (push) dat <= din;
         end

         assign dout  = dat;
         assign empty = ~vld;
         assign full  = vld;
      end else begin : g_fifo
         localparam int PW = $clog2(DP);
         localparam int CW = $clog2(DP + 1);

         logic [DW-1:0] mem [DP];
         logic [PW-1:0] wptr, rptr;
         logic [CW-1:0] cnt, cnt_nxt;

         // NOTE: every always_comb output gets a default first so no path
         // can leave it unassigned and infer a latch.
         always_comb begin
            cnt_nxt = cnt;
            if (push && !pop)      cnt_nxt = cnt + CW'(1);
            else if (pop && !push) cnt_nxt = cnt - CW'(1);
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               wptr <= '0;
               rptr <= '0;
               cnt  <= '0;
            end else begin
               cnt <= cnt_nxt;
               if (push) wptr <= (wptr == PW'(DP - 1)) ? '0 : wptr + PW'(1);
               if (pop)  rptr <= (rptr == PW'(DP - 1)) ? '0 : rptr + PW'(1);
            end
         end

         // NOTE: the storage array has no reset; the pointers and count are
         // reset, and nothing reads an entry that was not written.
         always_ff @(posedge clk) begin
            if (push) mem[wptr] <= din;
         end

         assign dout  = mem[rptr];
         assign empty = (cnt == '0);

         if (CUT_READY != 0) begin : g_full_reg
            logic full_q;
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) full_q <= 1'b0;
               else      full_q <= (cnt_nxt == CW'(DP));
            end
            assign full = full_q;
         end else begin : g_full_cmb
            assign full = (cnt == CW'(DP));
         end
      end
   endgenerate

endmodule

// File: rtl/icb_arbt_mux.sv
// -----------------------------------------------------------------------------
// icb_arbt_mux
// ICB N-to-1 round-robin arbiter. Merges ARBT_NUM upstream initiators onto one
// downstream target and routes in-order responses back through an
// outstanding-ID FIFO holding the one-hot grant of every accepted command.
// Optional feature: define ICB_ARBT_LOCK_EN to let cmd_lock=1 pin the grant to
// one port until that port completes a command with cmd_lock=0.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   i_bus_icb_cmd_*        packed upstream commands, port i at slice i
//   i_bus_icb_rsp_*        packed upstream responses (payload broadcast)
//   o_icb_cmd_*            granted downstream command
//   o_icb_rsp_*            downstream response
// -----------------------------------------------------------------------------
module icb_arbt_mux
   import icb_arbt_mux_pkg::*;
#(
   parameter int AW              = 32,
   parameter int DW              = 64,
   parameter int ARBT_NUM        = 4,
   parameter int FIFO_OUTS_NUM   = 8,
   parameter int FIFO_CUT_READY  = 0,
   parameter int ALLOW_0CYCL_RSP = 1,
   parameter int USR_W           = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ARBT_NUM-1:0]       i_bus_icb_cmd_valid,
   output logic [ARBT_NUM-1:0]       i_bus_icb_cmd_ready,
   input  logic [ARBT_NUM-1:0]       i_bus_icb_cmd_read,
   input  logic [ARBT_NUM*AW-1:0]    i_bus_icb_cmd_addr,
   input  logic [ARBT_NUM*DW-1:0]    i_bus_icb_cmd_wdata,
   input  logic [ARBT_NUM*DW/8-1:0]  i_bus_icb_cmd_wmask,
   input  logic [ARBT_NUM*2-1:0]     i_bus_icb_cmd_burst,
   input  logic [ARBT_NUM*2-1:0]     i_bus_icb_cmd_beat,
   input  logic [ARBT_NUM-1:0]       i_bus_icb_cmd_lock,
   input  logic [ARBT_NUM-1:0]       i_bus_icb_cmd_excl,
   input  logic [ARBT_NUM*2-1:0]     i_bus_icb_cmd_size,
   input  logic [ARBT_NUM*USR_W-1:0] i_bus_icb_cmd_usr,
   output logic [ARBT_NUM-1:0]       i_bus_icb_rsp_valid,
   input  logic [ARBT_NUM-1:0]       i_bus_icb_rsp_ready,
   output logic [ARBT_NUM-1:0]       i_bus_icb_rsp_err,
   output logic [ARBT_NUM-1:0]       i_bus_icb_rsp_excl_ok,
   output logic [ARBT_NUM*DW-1:0]    i_bus_icb_rsp_rdata,
   output logic [ARBT_NUM*USR_W-1:0] i_bus_icb_rsp_usr,
   output logic                      o_icb_cmd_valid,
   input  logic                      o_icb_cmd_ready,
   output logic                      o_icb_cmd_read,
   output logic [AW-1:0]             o_icb_cmd_addr,
   output logic [DW-1:0]             o_icb_cmd_wdata,
   output logic [DW/8-1:0]           o_icb_cmd_wmask,
   output logic [1:0]                o_icb_cmd_burst,
   output logic [1:0]                o_icb_cmd_beat,
   output logic                      o_icb_cmd_lock,
   output logic                      o_icb_cmd_excl,
   output logic [1:0]                o_icb_cmd_size,
   output logic [USR_W-1:0]          o_icb_cmd_usr,
   input  logic                      o_icb_rsp_valid,
   output logic                      o_icb_rsp_ready,
   input  logic                      o_icb_rsp_err,
   input  logic                      o_icb_rsp_excl_ok,
   input  logic [DW-1:0]             o_icb_rsp_rdata,
   input  logic [USR_W-1:0]          o_icb_rsp_usr
);

   localparam int PTR_W = $clog2(ARBT_NUM);
   localparam int MW    = DW / 8;

   arb_state_e          state, state_nxt;
   logic [PTR_W-1:0]    last_gnt;
   logic [ARBT_NUM-1:0] hi_req, pick, rr_gnt, gnt_q, gnt, gnt_v;
   logic [ARBT_NUM-1:0] rsp_id, fifo_head;
   logic                fifo_empty, fifo_full, fifo_push, fifo_pop;
   logic                cmd_hs, rsp_hs;

   // Round-robin: prefer requesters above last_gnt, else wrap to the lowest
   // requester; x & (~x + 1) isolates the lowest set bit.
   always_comb begin
      hi_req = '0;
      for (int i = 0; i < ARBT_NUM; i++) begin
         hi_req[i] = i_bus_icb_cmd_valid[i] && (i > int'(last_gnt));
      end
      pick   = (|hi_req) ? hi_req : i_bus_icb_cmd_valid;
      rr_gnt = pick & (~pick + ARBT_NUM'(1));
   end

   // Outside ARB the grant is frozen so the downstream payload stays stable.
   assign gnt                 = (state == ST_ARB) ? rr_gnt : gnt_q;
   assign gnt_v               = gnt & i_bus_icb_cmd_valid;
   assign o_icb_cmd_valid     = (|gnt_v) & ~fifo_full;
   assign i_bus_icb_cmd_ready = gnt_v & {ARBT_NUM{o_icb_cmd_ready & ~fifo_full}};
   assign cmd_hs              = o_icb_cmd_valid & o_icb_cmd_ready;

`ifdef ICB_ARBT_LOCK_EN
   logic cmd_lock;
   assign cmd_lock = |(gnt_v & i_bus_icb_cmd_lock);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_ARB;
         gnt_q    <= '0;
         last_gnt <= PTR_W'(ARBT_NUM - 1);
      end else begin
         state <= state_nxt;
         if (state == ST_ARB) gnt_q <= rr_gnt;
         if (cmd_hs) last_gnt <= PTR_W'(onehot_to_idx(32'(gnt_v)));
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ARB: begin
            if (o_icb_cmd_valid && !o_icb_cmd_ready) state_nxt = ST_HOLD;
`ifdef ICB_ARBT_LOCK_EN
            if (cmd_hs && cmd_lock) state_nxt = ST_LOCK;
`endif
         end
         ST_HOLD: begin
            if (cmd_hs) begin
               state_nxt = ST_ARB;
`ifdef ICB_ARBT_LOCK_EN
               if (cmd_lock) state_nxt = ST_LOCK;
`endif
            end
         end
`ifdef ICB_ARBT_LOCK_EN
         ST_LOCK: begin
            if (cmd_hs && !cmd_lock) state_nxt = ST_ARB;
         end
`endif
         default: state_nxt = ST_ARB;
      endcase
   end

   // AND-OR payload mux; all zero when nothing is granted.
   always_comb begin
      o_icb_cmd_read  = 1'b0;
      o_icb_cmd_addr  = '0;
      o_icb_cmd_wdata = '0;
      o_icb_cmd_wmask = '0;
      o_icb_cmd_burst = '0;
      o_icb_cmd_beat  = '0;
      o_icb_cmd_lock  = 1'b0;
      o_icb_cmd_excl  = 1'b0;
      o_icb_cmd_size  = '0;
      o_icb_cmd_usr   = '0;
      for (int i = 0; i < ARBT_NUM; i++) begin
         o_icb_cmd_read  = o_icb_cmd_read  | (gnt_v[i] & i_bus_icb_cmd_read[i]);
         o_icb_cmd_addr  = o_icb_cmd_addr  | ({AW{gnt_v[i]}}    & i_bus_icb_cmd_addr[i*AW +: AW]);
         o_icb_cmd_wdata = o_icb_cmd_wdata | ({DW{gnt_v[i]}}    & i_bus_icb_cmd_wdata[i*DW +: DW]);
         o_icb_cmd_wmask = o_icb_cmd_wmask | ({MW{gnt_v[i]}}    & i_bus_icb_cmd_wmask[i*MW +: MW]);
         o_icb_cmd_burst = o_icb_cmd_burst | ({2{gnt_v[i]}}     & i_bus_icb_cmd_burst[i*2 +: 2]);
         o_icb_cmd_beat  = o_icb_cmd_beat  | ({2{gnt_v[i]}}     & i_bus_icb_cmd_beat[i*2 +: 2]);
         o_icb_cmd_lock  = o_icb_cmd_lock  | (gnt_v[i] & i_bus_icb_cmd_lock[i]);
         o_icb_cmd_excl  = o_icb_cmd_excl  | (gnt_v[i] & i_bus_icb_cmd_excl[i]);
         o_icb_cmd_size  = o_icb_cmd_size  | ({2{gnt_v[i]}}     & i_bus_icb_cmd_size[i*2 +: 2]);
         o_icb_cmd_usr   = o_icb_cmd_usr   | ({USR_W{gnt_v[i]}} & i_bus_icb_cmd_usr[i*USR_W +: USR_W]);
      end
   end

   // Response port: FIFO head, or the live grant for a zero-cycle response.
   always_comb begin
      rsp_id = '0;
      if (!fifo_empty)               rsp_id = fifo_head;
      else if (ALLOW_0CYCL_RSP != 0) rsp_id = gnt_v;
   end

   assign i_bus_icb_rsp_valid   = rsp_id & {ARBT_NUM{o_icb_rsp_valid}};
   assign o_icb_rsp_ready       = |(rsp_id & i_bus_icb_rsp_ready);
   assign rsp_hs                = o_icb_rsp_valid & o_icb_rsp_ready;
   assign i_bus_icb_rsp_err     = {ARBT_NUM{o_icb_rsp_err}};
   assign i_bus_icb_rsp_excl_ok = {ARBT_NUM{o_icb_rsp_excl_ok}};
   assign i_bus_icb_rsp_rdata   = {ARBT_NUM{o_icb_rsp_rdata}};
   assign i_bus_icb_rsp_usr     = {ARBT_NUM{o_icb_rsp_usr}};

   // A command answered in its own cycle never enters the FIFO.
   assign fifo_push = cmd_hs & ~(fifo_empty & rsp_hs);
   assign fifo_pop  = rsp_hs & ~fifo_empty;

   icb_arbt_mux_fifo #(
      .DP        (FIFO_OUTS_NUM),
      .DW        (ARBT_NUM),
      .CUT_READY (FIFO_CUT_READY)
   ) u_id_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (gnt_v),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_icb_arbt_mux.sv
// -----------------------------------------------------------------------------
// tb_icb_arbt_mux
// Self-checking bench for icb_arbt_mux with default parameters
// (ARBT_NUM=4, FIFO_OUTS_NUM=8, ALLOW_0CYCL_RSP=1). Lock sequence runs only
// when ICB_ARBT_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_icb_arbt_mux;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int UW = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    i_bus_icb_cmd_valid, i_bus_icb_cmd_ready, i_bus_icb_cmd_read;
   logic [N*AW-1:0] i_bus_icb_cmd_addr;
   logic [N*DW-1:0] i_bus_icb_cmd_wdata;
   logic [N*DW/8-1:0] i_bus_icb_cmd_wmask;
   logic [N*2-1:0]  i_bus_icb_cmd_burst, i_bus_icb_cmd_beat, i_bus_icb_cmd_size;
   logic [N-1:0]    i_bus_icb_cmd_lock, i_bus_icb_cmd_excl;
   logic [N*UW-1:0] i_bus_icb_cmd_usr;
   logic [N-1:0]    i_bus_icb_rsp_valid, i_bus_icb_rsp_ready;
   logic [N-1:0]    i_bus_icb_rsp_err, i_bus_icb_rsp_excl_ok;
   logic [N*DW-1:0] i_bus_icb_rsp_rdata;
   logic [N*UW-1:0] i_bus_icb_rsp_usr;
   logic            o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read;
   logic [AW-1:0]   o_icb_cmd_addr;
   logic [DW-1:0]   o_icb_cmd_wdata;
   logic [DW/8-1:0] o_icb_cmd_wmask;
   logic [1:0]      o_icb_cmd_burst, o_icb_cmd_beat, o_icb_cmd_size;
   logic            o_icb_cmd_lock, o_icb_cmd_excl;
   logic [UW-1:0]   o_icb_cmd_usr;
   logic            o_icb_rsp_valid, o_icb_rsp_ready, o_icb_rsp_err, o_icb_rsp_excl_ok;
   logic [DW-1:0]   o_icb_rsp_rdata;
   logic [UW-1:0]   o_icb_rsp_usr;

   int n_err    = 0;
   int n_checks = 0;

   always #5 clk = ~clk;

   icb_arbt_mux dut (
      .clk                   (clk),
      .rst                   (rst),
      .i_bus_icb_cmd_valid   (i_bus_icb_cmd_valid),
      .i_bus_icb_cmd_ready   (i_bus_icb_cmd_ready),
      .i_bus_icb_cmd_read    (i_bus_icb_cmd_read),
      .i_bus_icb_cmd_addr    (i_bus_icb_cmd_addr),
      .i_bus_icb_cmd_wdata   (i_bus_icb_cmd_wdata),
      .i_bus_icb_cmd_wmask   (i_bus_icb_cmd_wmask),
      .i_bus_icb_cmd_burst   (i_bus_icb_cmd_burst),
      .i_bus_icb_cmd_beat    (i_bus_icb_cmd_beat),
      .i_bus_icb_cmd_lock    (i_bus_icb_cmd_lock),
      .i_bus_icb_cmd_excl    (i_bus_icb_cmd_excl),
      .i_bus_icb_cmd_size    (i_bus_icb_cmd_size),
      .i_bus_icb_cmd_usr     (i_bus_icb_cmd_usr),
      .i_bus_icb_rsp_valid   (i_bus_icb_rsp_valid),
      .i_bus_icb_rsp_ready   (i_bus_icb_rsp_ready),
      .i_bus_icb_rsp_err     (i_bus_icb_rsp_err),
      .i_bus_icb_rsp_excl_ok (i_bus_icb_rsp_excl_ok),
      .i_bus_icb_rsp_rdata   (i_bus_icb_rsp_rdata),
      .i_bus_icb_rsp_usr     (i_bus_icb_rsp_usr),
      .o_icb_cmd_valid       (o_icb_cmd_valid),
      .o_icb_cmd_ready       (o_icb_cmd_ready),
      .o_icb_cmd_read        (o_icb_cmd_read),
      .o_icb_cmd_addr        (o_icb_cmd_addr),
      .o_icb_cmd_wdata       (o_icb_cmd_wdata),
      .o_icb_cmd_wmask       (o_icb_cmd_wmask),
      .o_icb_cmd_burst       (o_icb_cmd_burst),
      .o_icb_cmd_beat        (o_icb_cmd_beat),
      .o_icb_cmd_lock        (o_icb_cmd_lock),
      .o_icb_cmd_excl        (o_icb_cmd_excl),
      .o_icb_cmd_size        (o_icb_cmd_size),
      .o_icb_cmd_usr         (o_icb_cmd_usr),
      .o_icb_rsp_valid       (o_icb_rsp_valid),
      .o_icb_rsp_ready       (o_icb_rsp_ready),
      .o_icb_rsp_err         (o_icb_rsp_err),
      .o_icb_rsp_excl_ok     (o_icb_rsp_excl_ok),
      .o_icb_rsp_rdata       (o_icb_rsp_rdata),
      .o_icb_rsp_usr         (o_icb_rsp_usr)
   );

   typedef struct {
      logic [3:0]  valid;
      logic        cmd_rdy;
      logic        rsp_vld;
      logic [3:0]  rsp_rdy;
      logic [3:0]  e_cmd_rdy;
      logic        e_o_vld;
      logic [31:0] e_addr;
      logic [3:0]  e_rsp_vld;
      logic        e_rsp_rdy;
   } vec_t;

   vec_t vt [16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cmd(input string nm, input logic [3:0] e_rdy, input logic e_vld);
      @(negedge clk);
      check({nm, "_rdy"}, 64'(i_bus_icb_cmd_ready), 64'(e_rdy));
      check({nm, "_vld"}, 64'(o_icb_cmd_valid), 64'(e_vld));
   endtask

   task automatic expect_rsp(input string nm, input logic [3:0] e_vld);
      @(negedge clk);
      check({nm, "_rspv"}, 64'(i_bus_icb_rsp_valid), 64'(e_vld));
   endtask

   initial begin
      //           valid  crdy  rvld  rrdy | e_crdy e_ov e_addr        e_rv   e_rr
      vt[0]  = '{4'b0000, 1'b1, 1'b0, 4'hF, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 1'b0};
      vt[1]  = '{4'b0101, 1'b1, 1'b0, 4'hF, 4'b0001, 1'b1, 32'h0000_1000, 4'b0000, 1'b1};
      vt[2]  = '{4'b0101, 1'b1, 1'b0, 4'hF, 4'b0100, 1'b1, 32'h0000_3000, 4'b0000, 1'b1};
      vt[3]  = '{4'b0101, 1'b1, 1'b0, 4'hF, 4'b0001, 1'b1, 32'h0000_1000, 4'b0000, 1'b1};
      vt[4]  = '{4'b0101, 1'b1, 1'b0, 4'hF, 4'b0100, 1'b1, 32'h0000_3000, 4'b0000, 1'b1};
      vt[5]  = '{4'b0000, 1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 32'h0000_0000, 4'b0001, 1'b1};
      vt[6]  = '{4'b0000, 1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 32'h0000_0000, 4'b0100, 1'b1};
      vt[7]  = '{4'b0000, 1'b1, 1'b1, 4'hB, 4'b0000, 1'b0, 32'h0000_0000, 4'b0001, 1'b1};
      vt[8]  = '{4'b0000, 1'b1, 1'b1, 4'hB, 4'b0000, 1'b0, 32'h0000_0000, 4'b0100, 1'b0};
      vt[9]  = '{4'b0000, 1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 32'h0000_0000, 4'b0100, 1'b1};
      vt[10] = '{4'b0100, 1'b1, 1'b1, 4'hF, 4'b0100, 1'b1, 32'h0000_3000, 4'b0100, 1'b1};
      vt[11] = '{4'b0000, 1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 1'b0};
      vt[12] = '{4'b1010, 1'b1, 1'b0, 4'hF, 4'b1000, 1'b1, 32'h0000_4000, 4'b0000, 1'b1};
      vt[13] = '{4'b1010, 1'b1, 1'b0, 4'hF, 4'b0010, 1'b1, 32'h0000_2000, 4'b0000, 1'b1};
      vt[14] = '{4'b0000, 1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 32'h0000_0000, 4'b1000, 1'b1};
      vt[15] = '{4'b0000, 1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 32'h0000_0000, 4'b0010, 1'b1};

      rst = 1'b0;
      i_bus_icb_cmd_valid = '0;  i_bus_icb_cmd_read  = '0;  i_bus_icb_cmd_wmask = '0;
      i_bus_icb_cmd_burst = '0;  i_bus_icb_cmd_beat  = '0;  i_bus_icb_cmd_size  = '0;
      i_bus_icb_cmd_lock  = '0;  i_bus_icb_cmd_excl  = '0;  i_bus_icb_cmd_usr   = '0;
      i_bus_icb_rsp_ready = '1;  o_icb_cmd_ready     = 1'b0;
      o_icb_rsp_valid = 1'b0; o_icb_rsp_err = 1'b0; o_icb_rsp_excl_ok = 1'b0;
      o_icb_rsp_rdata = '0;   o_icb_rsp_usr = '0;
      for (int i = 0; i < N; i++) begin
         i_bus_icb_cmd_addr[i*AW +: AW]  = 32'h1000 * (i + 1);
         i_bus_icb_cmd_wdata[i*DW +: DW] = 64'hDA7A_0000_0000_0000 | 64'(i);
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // Table: round-robin 0,2,0,2, in-order drain, backpressured response,
      // zero-cycle bypass, wrap from port 3 to port 1.
      for (int n = 0; n < 16; n++) begin
         i_bus_icb_cmd_valid = vt[n].valid;
         o_icb_cmd_ready     = vt[n].cmd_rdy;
         o_icb_rsp_valid     = vt[n].rsp_vld;
         i_bus_icb_rsp_ready = vt[n].rsp_rdy;
         @(negedge clk);
         check($sformatf("v%0d_cmd_rdy", n), 64'(i_bus_icb_cmd_ready), 64'(vt[n].e_cmd_rdy));
         check($sformatf("v%0d_o_vld", n),   64'(o_icb_cmd_valid),     64'(vt[n].e_o_vld));
         check($sformatf("v%0d_addr", n),    64'(o_icb_cmd_addr),      64'(vt[n].e_addr));
         check($sformatf("v%0d_rsp_vld", n), 64'(i_bus_icb_rsp_valid), 64'(vt[n].e_rsp_vld));
         check($sformatf("v%0d_rsp_rdy", n), 64'(o_icb_rsp_ready),     64'(vt[n].e_rsp_rdy));
         next_cycle();
      end
      o_icb_rsp_valid = 1'b0;
      i_bus_icb_rsp_ready = '1;

      // HOLD: port 1 stalled three cycles; port 0 arriving must not steal it.
      i_bus_icb_cmd_valid = 4'b0010; o_icb_cmd_ready = 1'b0;
      expect_cmd("hold_a", 4'b0000, 1'b1);
      check("hold_a_addr", 64'(o_icb_cmd_addr), 64'h2000);
      next_cycle();
      i_bus_icb_cmd_valid = 4'b0011;
      for (int k = 0; k < 2; k++) begin
         expect_cmd($sformatf("hold_b%0d", k), 4'b0000, 1'b1);
         check($sformatf("hold_b%0d_addr", k), 64'(o_icb_cmd_addr), 64'h2000);
         check($sformatf("hold_b%0d_wdata", k), o_icb_cmd_wdata, 64'hDA7A_0000_0000_0001);
         next_cycle();
      end
      o_icb_cmd_ready = 1'b1;
      expect_cmd("hold_hs", 4'b0010, 1'b1);
      check("hold_hs_addr", 64'(o_icb_cmd_addr), 64'h2000);
      next_cycle();
      i_bus_icb_cmd_valid = 4'b0001;
      expect_cmd("hold_next", 4'b0001, 1'b1);
      next_cycle();
      i_bus_icb_cmd_valid = 4'b0000; o_icb_rsp_valid = 1'b1;
      expect_rsp("hold_r1", 4'b0010); next_cycle();
      expect_rsp("hold_r2", 4'b0001); next_cycle();
      o_icb_rsp_valid = 1'b0;

      // FIFO full: 8 outstanding, 9th blocked, pop frees a slot one cycle later.
      i_bus_icb_cmd_valid = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         expect_cmd($sformatf("fill%0d", k), 4'b0001, 1'b1);
         next_cycle();
      end
      expect_cmd("full", 4'b0000, 1'b0);
      next_cycle();
      o_icb_rsp_valid = 1'b1;
      expect_cmd("full_pop", 4'b0000, 1'b0);
      check("full_pop_rspv", 64'(i_bus_icb_rsp_valid), 64'h1);
      next_cycle();
      o_icb_rsp_valid = 1'b0;
      expect_cmd("full_free", 4'b0001, 1'b1);
      next_cycle();
      i_bus_icb_cmd_valid = 4'b0000; o_icb_rsp_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         expect_rsp($sformatf("drain%0d", k), 4'b0001);
         next_cycle();
      end
      expect_rsp("drained", 4'b0000);
      check("drained_rrdy", 64'(o_icb_rsp_ready), 64'h0);
      next_cycle();
      o_icb_rsp_valid = 1'b0;

      // Routing: commands from 3, 1, 3; responses A, B, C in order.
      i_bus_icb_cmd_valid = 4'b1000; expect_cmd("rt_c0", 4'b1000, 1'b1); next_cycle();
      i_bus_icb_cmd_valid = 4'b0010; expect_cmd("rt_c1", 4'b0010, 1'b1); next_cycle();
      i_bus_icb_cmd_valid = 4'b1000; expect_cmd("rt_c2", 4'b1000, 1'b1); next_cycle();
      i_bus_icb_cmd_valid = 4'b0000; o_icb_rsp_valid = 1'b1;
      o_icb_rsp_rdata = 64'hAAAA_0000_0000_000A; o_icb_rsp_err = 1'b1; o_icb_rsp_excl_ok = 1'b0;
      expect_rsp("rt_a", 4'b1000);
      check("rt_a_rdata", i_bus_icb_rsp_rdata[3*DW +: DW], 64'hAAAA_0000_0000_000A);
      check("rt_a_err", 64'(i_bus_icb_rsp_err[3]), 64'h1);
      next_cycle();
      o_icb_rsp_rdata = 64'hBBBB_0000_0000_000B; o_icb_rsp_err = 1'b0; o_icb_rsp_excl_ok = 1'b1;
      expect_rsp("rt_b", 4'b0010);
      check("rt_b_rdata", i_bus_icb_rsp_rdata[1*DW +: DW], 64'hBBBB_0000_0000_000B);
      check("rt_b_excl", 64'(i_bus_icb_rsp_excl_ok[1]), 64'h1);
      next_cycle();
      o_icb_rsp_rdata = 64'hCCCC_0000_0000_000C; o_icb_rsp_excl_ok = 1'b0;
      expect_rsp("rt_c", 4'b1000);
      check("rt_c_rdata", i_bus_icb_rsp_rdata[3*DW +: DW], 64'hCCCC_0000_0000_000C);
      next_cycle();
      o_icb_rsp_valid = 1'b0;

      // Reset mid-operation flushes the FIFO and restores last_gnt.
      i_bus_icb_cmd_valid = 4'b0100;
      expect_cmd("rst_pre", 4'b0100, 1'b1);
      next_cycle();
      i_bus_icb_cmd_valid = 4'b0000;
      rst = 1'b0;
      #2;
      rst = 1'b1;
      o_icb_rsp_valid = 1'b1;
      expect_rsp("rst_flush", 4'b0000);
      check("rst_flush_rrdy", 64'(o_icb_rsp_ready), 64'h0);
      next_cycle();
      o_icb_rsp_valid = 1'b0;
      i_bus_icb_cmd_valid = 4'b1001;
      expect_cmd("rst_prio", 4'b0001, 1'b1);
      next_cycle();
      i_bus_icb_cmd_valid = 4'b0000; o_icb_rsp_valid = 1'b1;
      expect_rsp("rst_r", 4'b0001); next_cycle();
      o_icb_rsp_valid = 1'b0;

`ifdef ICB_ARBT_LOCK_EN
      // Lock: port 1 keeps the bus through lock=1, lock=1, lock=0.
      i_bus_icb_cmd_valid = 4'b0010; i_bus_icb_cmd_lock = 4'b0010;
      expect_cmd("lk1", 4'b0010, 1'b1);
      check("lk1_lock", 64'(o_icb_cmd_lock), 64'h1);
      next_cycle();
      i_bus_icb_cmd_valid = 4'b0011;
      expect_cmd("lk2", 4'b0010, 1'b1); next_cycle();
      i_bus_icb_cmd_lock = 4'b0000;
      expect_cmd("lk3", 4'b0010, 1'b1); next_cycle();
      i_bus_icb_cmd_valid = 4'b0001;
      expect_cmd("lk4", 4'b0001, 1'b1); next_cycle();
      i_bus_icb_cmd_valid = 4'b0000; o_icb_rsp_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         expect_rsp($sformatf("lk_r%0d", k), 4'b0010); next_cycle();
      end
      expect_rsp("lk_r3", 4'b0001); next_cycle();
      o_icb_rsp_valid = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
